countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter COUNT_LEN, default 10; counter width SHALL be COUNT_LEN+1 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 load  input  1  start/restart request; loads load_value.
REQ-005 load_value  input  COUNT_LEN+1  terminal-count start value N.
REQ-006 enable  input  1  decrement qualifier; count SHALL hold when low.
REQ-007 auto_reload  input  1  when high at terminal count, SHALL restart from stored N.
REQ-008 count  output  COUNT_LEN+1  registered current count.
REQ-009 busy  output  1  registered; high while in RUN state.
REQ-010 done  output  1  registered single-cycle terminal-count pulse.
REQ-011 zero  output  1  combinational, equals (count == 0).

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 The block SHALL hold an internal reload register capturing load_value on every accepted load.
REQ-014 IDLE, load=1, load_value!=0: next edge SHALL set count=load_value, store reload, busy=1, go to RUN.
REQ-015 IDLE, load=1, load_value==0: next edge SHALL set count=0, done=1 for one cycle, stay in IDLE.
REQ-016 IDLE, load=0: count SHALL hold; enable SHALL be ignored; done=0.
REQ-017 RUN, load=0, enable=1, count>1: next edge SHALL decrement count by 1; done=0.
REQ-018 RUN, load=0, enable=1, count==1, auto_reload=0: next edge SHALL set count=0, done=1, busy=0, go to IDLE.
REQ-019 RUN, load=0, enable=1, count==1, auto_reload=1: next edge SHALL set count=reload value, done=1, stay in RUN; count SHALL NOT present 0.
REQ-020 RUN, enable=0: count SHALL hold; done=0; state unchanged.
REQ-021 load SHALL take priority over enable in any state; a load in RUN SHALL restart per REQ-014/REQ-015, discarding the in-flight count without a done pulse (except the REQ-015 pulse for N=0).
REQ-022 count SHALL never wrap below 0 nor be incremented.
REQ-023 Latency: load of N (N>=1) at edge 0 with enable held high SHALL produce done=1 in the cycle following edge N.
REQ-024 With auto_reload=1 and enable held high, done SHALL pulse every N cycles.
REQ-025 N = 2^(COUNT_LEN+1)-1 (all ones) SHALL count fully without overflow.
REQ-026 done SHALL be high for exactly one cycle per terminal event, never on consecutive cycles unless N==1 with auto_reload=1.

Reset
REQ-027 reset=1 at a rising edge SHALL force count=0, busy=0, done=0, reload register=0, state IDLE, overriding load and enable.
REQ-028 reset asserted mid-RUN SHALL abort the count with no done pulse.
REQ-029 After reset deasserts, the block SHALL accept a load on the first following edge.

Verification
REQ-030 Reset, load N=5, enable=1 constantly -> count 5,4,3,2,1,0; done=1 in cycle after count reaches 0; busy falls with it.
REQ-031 Load N=3, auto_reload=1, enable=1 for 10 cycles -> count 3,2,1,3,2,1,3,...; done pulses every 3 cycles; busy stays 1.
REQ-032 Load N=6, enable toggled 1,0,1,0... -> count decrements only on enabled edges; done after 6 enabled edges.
REQ-033 Load N=8, after 3 decrements assert load with N=2 -> count=2, no done for first run; done after 2 more cycles.
REQ-034 Load N=0 -> count=0, done single pulse, busy stays 0; enable in IDLE leaves count 0.
REQ-035 Load N=4, assert reset after 2 decrements -> count=0, busy=0, done never asserted.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with enable gating and optional auto-reload; count/busy/done are registered.
// A load of N with enable held high gives a one-cycle done N edges later. There is no backpressure; a low enable stalls the count.
module countdown_timer #(
  parameter int COUNT_LEN = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [COUNT_LEN:0]   load_value,
  input  logic                 enable,
  input  logic                 auto_reload,
  output logic [COUNT_LEN:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic                 zero
);

  localparam int W = COUNT_LEN + 1;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (load) begin
      // A load always restarts; any in-flight count is dropped silently.
      reload_d = load_value;
      count_d  = load_value;
      if (load_value != '0) begin
        state_d = RUN;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN && enable) begin
      if (count_q != ONE) begin
        count_d = count_q - ONE;
      end else begin
        done_d = 1'b1;
        // Reload straight from 1 so the count never shows 0 while periodic.
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a behavioural model.
module tb_countdown_timer;
  localparam int CL = 10;
  localparam int W  = CL + 1;
  localparam int MAXN = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, load, enable, auto_reload;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         busy, done, zero;

  int checks = 0;
  int failures = 0;

  // Reference model state: remaining count, running flag, stored N, pulse.
  int m_cnt, m_rel;
  bit m_run, m_done;
  int dut_dones;

  countdown_timer #(.COUNT_LEN(CL)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_cnt = 0; m_run = 0; m_rel = 0; m_done = 0;
    end else if (load) begin
      m_rel  = int'(load_value);
      m_cnt  = m_rel;
      m_run  = (m_rel != 0);
      m_done = (m_rel == 0);
    end else if (m_run && enable) begin
      if (m_cnt > 1) begin
        m_cnt  = m_cnt - 1;
        m_done = 0;
      end else begin
        m_done = 1;
        if (auto_reload) m_cnt = m_rel;
        else begin
          m_cnt = 0;
          m_run = 0;
        end
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (done === 1'b1) dut_dones++;
    check("count", 32'(count), 32'(m_cnt));
    check("busy",  32'(busy),  32'(m_run));
    check("done",  32'(done),  32'(m_done));
    check("zero",  32'(zero),  32'(m_cnt == 0));
  endtask

  initial begin
    int first_done;
    reset = 1; load = 0; enable = 0; auto_reload = 0; load_value = '0;
    m_cnt = 0; m_rel = 0; m_run = 0; m_done = 0; dut_dones = 0;
    @(negedge clk);
    step(); step();
    reset = 0;

    // Basic countdown N=5.
    load = 1; load_value = W'(5); enable = 1;
    step();
    load = 0; dut_dones = 0; first_done = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (done === 1'b1 && first_done < 0) first_done = i;
    end
    check("n5_done_edge", 32'(first_done), 32'd5);
    check("n5_done_count", 32'(dut_dones), 32'd1);

    // Auto-reload N=3 for 10 cycles.
    auto_reload = 1; load = 1; load_value = W'(3);
    step();
    load = 0; dut_dones = 0;
    repeat (10) step();
    check("ar3_dones", 32'(dut_dones), 32'd3);
    check("ar3_busy", 32'(busy), 32'd1);

    // Enable toggling N=6.
    auto_reload = 0; load = 1; load_value = W'(6); enable = 1;
    step();
    load = 0; dut_dones = 0; first_done = -1;
    for (int i = 0; i < 12; i++) begin
      enable = (i % 2 == 0);
      step();
      if (done === 1'b1 && first_done < 0) first_done = i;
    end
    check("tog6_done_idx", 32'(first_done), 32'd10);
    check("tog6_dones", 32'(dut_dones), 32'd1);

    // Restart mid-run: N=8, 3 decrements, reload with N=2.
    enable = 1; load = 1; load_value = W'(8);
    step();
    load = 0; dut_dones = 0;
    repeat (3) step();
    load = 1; load_value = W'(2);
    step();
    load = 0;
    check("restart_no_done", 32'(dut_dones), 32'd0);
    repeat (2) step();
    check("restart_done", 32'(dut_dones), 32'd1);

    // N=0 load: single pulse, stays idle.
    load = 1; load_value = '0;
    step();
    load = 0; enable = 1; dut_dones = 1;
    repeat (3) step();
    check("n0_single_pulse", 32'(dut_dones), 32'd1);

    // Reset mid-run, then load on the first edge after reset.
    load = 1; load_value = W'(4);
    step();
    load = 0; dut_dones = 0;
    repeat (2) step();
    reset = 1;
    step();
    reset = 0; load = 1; load_value = W'(3);
    step();
    check("abort_no_done", 32'(dut_dones), 32'd0);
    load = 0;
    repeat (4) step();

    // All-ones N counts fully without overflow.
    load = 1; load_value = W'(MAXN);
    step();
    load = 0; dut_dones = 0;
    repeat (MAXN) step();
    check("max_dones", 32'(dut_dones), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      load        = ($urandom_range(0, 9) == 0);
      load_value  = W'($urandom_range(0, 6));
      enable      = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
